// File: rtl/vec_alu_seq_pkg.sv
// Shared types and helpers for the vector ALU sequencer and its lane writeback.
package vec_alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StResp
  } state_e;

  // Operand type encodings (one-hot)
  localparam logic [2:0] OpTypeVv = 3'b001;
  localparam logic [2:0] OpTypeVx = 3'b010;
  localparam logic [2:0] OpTypeVi = 3'b100;

  // Element width codes, SEW = 8 << vsew
  localparam logic [2:0] Vsew8  = 3'd0;
  localparam logic [2:0] Vsew16 = 3'd1;
  localparam logic [2:0] Vsew32 = 3'd2;
  localparam logic [2:0] Vsew64 = 3'd3;

  // Per-lane field widths on the wrapper interface
  localparam int unsigned LaneDataW = 64;
  localparam int unsigned LaneIdxW  = 10;

  // Bits written per lane chunk: an element never spans more than one lane chunk width
  function automatic int unsigned chunk_width(input logic [2:0] vsew,
                                              input int unsigned lane_width);
    int unsigned sew;
    int unsigned lane_cw;
    sew     = 32'd8 << vsew;
    lane_cw = 32'd1 << lane_width;
    return (sew < lane_cw) ? sew : lane_cw;
  endfunction

  function automatic logic vsew_legal(input logic [2:0] vsew, input int unsigned vlen);
    return (vsew <= Vsew64) && ((32'd8 << vsew) <= vlen);
  endfunction

endpackage

// File: rtl/vec_lane_writeback.sv
// Delays lane indices/enables to line up with ALU data, then merges lane chunks into vd.
module vec_lane_writeback
  import vec_alu_seq_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 4,
  parameter int unsigned NB_LANES   = 3,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic                              clk_i,
  input  logic                              resetn_i,
  input  logic                              flush_i,   // new op: clear pipe and result
  input  logic                              push_i,    // capture lane indices this cycle
  input  logic                              wr_en_i,   // apply delayed lane writes
  input  logic [2:0]                        vsew_i,
  input  logic [(LaneDataW<<NB_LANES)-1:0]  alu_vd_i,
  input  logic [(LaneIdxW<<NB_LANES)-1:0]   alu_regi_i,
  input  logic [(1<<NB_LANES)-1:0]          alu_res_i,
  output logic [VLEN-1:0]                   vd_o
);

  localparam int unsigned Lanes    = 1 << NB_LANES;
  localparam int unsigned ChunkMax = 1 << LANE_WIDTH;
  localparam int unsigned IdxW     = $clog2(VLEN);
  localparam int unsigned PipeW    = (LaneIdxW + 1) * Lanes;

  logic [PipeW-1:0]          pipe_q [ALU_LAT];
  logic [PipeW-1:0]          pipe_in;
  logic [LaneIdxW*Lanes-1:0] regi_dly;
  logic [Lanes-1:0]          res_dly;
  logic [VLEN-1:0]           vd_d, vd_q;
  int unsigned               cw;
  int unsigned               base;
  logic [IdxW-1:0]           pos;
  logic                      unused_vd;

  // Only the low chunk of each lane carries data
  assign unused_vd = ^alu_vd_i;

  assign pipe_in             = push_i ? {alu_regi_i, alu_res_i} : '0;
  assign {regi_dly, res_dly} = pipe_q[ALU_LAT-1];
  assign vd_o                = vd_q;

  // Lane index/enable delay line, ALU_LAT stages
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < ALU_LAT; i++) pipe_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ALU_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < ALU_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Merge delayed lane chunks; chunks that would run past VLEN are dropped whole
  always_comb begin
    vd_d = vd_q;
    cw   = chunk_width(vsew_i, LANE_WIDTH);
    base = 0;
    pos  = '0;
    if (flush_i) begin
      vd_d = '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < Lanes; k++) begin
        base = 32'(regi_dly[k*LaneIdxW +: LaneIdxW]);
        if (res_dly[k] && (base + cw <= VLEN)) begin
          for (int b = 0; b < ChunkMax; b++) begin
            if (b < cw) begin
              pos       = IdxW'(base + b);
              vd_d[pos] = alu_vd_i[k*LaneDataW + b];
            end
          end
        end
      end
    end
  end

  // Destination register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) vd_q <= '0;
    else           vd_q <= vd_d;
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Sequences one vector ALU op per request through the wrapper and returns the merged result.
module vec_alu_seq
  import vec_alu_seq_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 4,
  parameter int unsigned NB_LANES   = 3,
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                             clk_i,
  input  logic                             resetn_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [5:0]                       req_opcode_i,
  input  logic [2:0]                       req_vsew_i,
  input  logic [2:0]                       req_optype_i,
  input  logic [VLEN-1:0]                  req_vs1_i,
  input  logic [VLEN-1:0]                  req_vs2_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [VLEN-1:0]                  rsp_vd_o,
  output logic                             rsp_err_o,
  output logic                             alu_run_o,
  output logic [5:0]                       alu_opcode_o,
  output logic [2:0]                       alu_vsew_o,
  output logic [2:0]                       alu_optype_o,
  output logic [VLEN-1:0]                  alu_vs1_o,
  output logic [VLEN-1:0]                  alu_vs2_o,
  input  logic [(LaneDataW<<NB_LANES)-1:0] alu_vd_i,
  input  logic [(LaneIdxW<<NB_LANES)-1:0]  alu_regi_i,
  input  logic [(1<<NB_LANES)-1:0]         alu_res_i,
  input  logic                             alu_done_i
);

  localparam int unsigned CntW   = $clog2(TIMEOUT + 1);
  localparam int unsigned DrainW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              err_q, err_d;
  logic              accept;
  logic [5:0]        opcode_q;
  logic [2:0]        vsew_q, optype_q;
  logic [VLEN-1:0]   vs1_q, vs2_q;

  assign accept       = req_valid_i && (state_q == StIdle);
  assign req_ready_o  = (state_q == StIdle);
  assign rsp_valid_o  = (state_q == StResp);
  assign alu_run_o    = (state_q == StRun);
  assign rsp_err_o    = err_q;
  assign alu_opcode_o = opcode_q;
  assign alu_vsew_o   = vsew_q;
  assign alu_optype_o = optype_q;
  assign alu_vs1_o    = vs1_q;
  assign alu_vs2_o    = vs2_q;

  // Next-state logic: illegal vsew skips RUN; timeout skips DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          cnt_d   = '0;
          drain_d = '0;
          if (vsew_legal(req_vsew_i, VLEN)) begin
            state_d = StRun;
            err_d   = 1'b0;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
          end
        end
      end
      StRun: begin
        if (alu_done_i) begin
          state_d = StDrain;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          state_d = StResp;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DrainW'(ALU_LAT - 1)) state_d = StResp;
        else                                 drain_d = drain_q + 1'b1;
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, cycle counter and error flag
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

  // Latch the decoded op on acceptance; held stable for the wrapper
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      opcode_q <= '0;
      vsew_q   <= '0;
      optype_q <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
    end else if (accept) begin
      opcode_q <= req_opcode_i;
      vsew_q   <= req_vsew_i;
      optype_q <= req_optype_i;
      vs1_q    <= req_vs1_i;
      vs2_q    <= req_vs2_i;
    end
  end

  vec_lane_writeback #(
    .VLEN       (VLEN),
    .LANE_WIDTH (LANE_WIDTH),
    .NB_LANES   (NB_LANES),
    .ALU_LAT    (ALU_LAT)
  ) u_writeback (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .flush_i    (accept),
    .push_i     (state_q == StRun),
    .wr_en_i    ((state_q == StRun) || (state_q == StDrain)),
    .vsew_i     (vsew_q),
    .alu_vd_i   (alu_vd_i),
    .alu_regi_i (alu_regi_i),
    .alu_res_i  (alu_res_i),
    .vd_o       (rsp_vd_o)
  );

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq with a behavioural lane-wrapper stub.
module tb_vec_alu_seq;
  import vec_alu_seq_pkg::*;

  localparam int unsigned VLEN       = 128;
  localparam int unsigned LANE_WIDTH = 4;
  localparam int unsigned NB_LANES   = 3;
  localparam int unsigned ALU_LAT    = 2;
  localparam int unsigned TIMEOUT    = 15;
  localparam int unsigned Lanes      = 1 << NB_LANES;

  typedef struct {
    logic [VLEN-1:0] vd;
    logic            err;
    int              lat;      // -1: not checked
    int              acc_cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  resetn = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [5:0]            req_opcode = '0;
  logic [2:0]            req_vsew = '0;
  logic [2:0]            req_optype = '0;
  logic [VLEN-1:0]       req_vs1 = '0;
  logic [VLEN-1:0]       req_vs2 = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [VLEN-1:0]       rsp_vd;
  logic                  rsp_err;
  logic                  alu_run;
  logic [5:0]            alu_opcode;
  logic [2:0]            alu_vsew;
  logic [2:0]            alu_optype;
  logic [VLEN-1:0]       alu_vs1;
  logic [VLEN-1:0]       alu_vs2;
  logic [64*Lanes-1:0]   alu_vd = '0;
  logic [10*Lanes-1:0]   alu_regi = '0;
  logic [Lanes-1:0]      alu_res = '0;
  logic                  alu_done = 1'b0;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_rsp = 0;
  int   run_cnt = 0;

  // Stub configuration, set by the test before each op
  int              stub_cw = 8;
  int              stub_ngroups = 2;
  bit              stub_oob = 1'b0;
  bit              stub_hang = 1'b0;
  logic [VLEN-1:0] stub_vec = '0;

  vec_alu_seq #(
    .VLEN       (VLEN),
    .LANE_WIDTH (LANE_WIDTH),
    .NB_LANES   (NB_LANES),
    .ALU_LAT    (ALU_LAT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_opcode_i (req_opcode),
    .req_vsew_i   (req_vsew),
    .req_optype_i (req_optype),
    .req_vs1_i    (req_vs1),
    .req_vs2_i    (req_vs2),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_vd_o     (rsp_vd),
    .rsp_err_o    (rsp_err),
    .alu_run_o    (alu_run),
    .alu_opcode_o (alu_opcode),
    .alu_vsew_o   (alu_vsew),
    .alu_optype_o (alu_optype),
    .alu_vs1_o    (alu_vs1),
    .alu_vs2_o    (alu_vs2),
    .alu_vd_i     (alu_vd),
    .alu_regi_i   (alu_regi),
    .alu_res_i    (alu_res),
    .alu_done_i   (alu_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [VLEN-1:0] got,
                          input logic [VLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element-wise add, elements of sew bits
  function automatic logic [VLEN-1:0] vadd(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                           input int sew);
    logic [VLEN-1:0] r;
    logic [63:0]     m, x, y;
    r = '0;
    m = (sew == 64) ? '1 : ((64'd1 << sew) - 64'd1);
    for (int e = 0; e < VLEN / sew; e++) begin
      x = 64'(a >> (e * sew)) & m;
      y = 64'(b >> (e * sew)) & m;
      r = r | (VLEN'((x + y) & m) << (e * sew));
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (alu_run) run_cnt++;
  end

  // Wrapper stub: 8 chunks per cycle while run is high, data ALU_LAT cycles behind regi/res
  initial begin : alu_stub
    logic [63:0] dly [ALU_LAT][Lanes];
    logic [63:0] cur [Lanes];
    logic [63:0] m;
    int g;
    int j;
    g = 0;
    for (int i = 0; i < ALU_LAT; i++)
      for (int k = 0; k < Lanes; k++) dly[i][k] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < Lanes; k++) alu_vd[k*64 +: 64] = dly[ALU_LAT-1][k];
      for (int i = ALU_LAT - 1; i > 0; i--)
        for (int k = 0; k < Lanes; k++) dly[i][k] = dly[i-1][k];
      alu_res  = '0;
      alu_regi = '0;
      alu_done = 1'b0;
      m = (64'd1 << stub_cw) - 64'd1;
      for (int k = 0; k < Lanes; k++) cur[k] = {$urandom, $urandom};
      if (resetn && alu_run && !stub_hang) begin
        for (int k = 0; k < Lanes; k++) begin
          j = g * Lanes + k;
          if (j * stub_cw < VLEN) begin
            alu_regi[k*10 +: 10] = 10'(j * stub_cw);
            alu_res[k]           = 1'b1;
            cur[k] = (cur[k] & ~m) | (64'(stub_vec >> (j * stub_cw)) & m);
          end else if (stub_oob && (g == stub_ngroups - 1) && (k == 0)) begin
            // Chunk straddling the top of vd: must be discarded
            alu_regi[k*10 +: 10] = 10'(VLEN - stub_cw / 2);
            alu_res[k]           = 1'b1;
            cur[k]               = '1;
          end
        end
        if (g == stub_ngroups - 1) alu_done = 1'b1;
        g++;
      end else begin
        g = 0;
      end
      for (int k = 0; k < Lanes; k++) dly[0][k] = cur[k];
    end
  end

  // Response side of the scoreboard
  initial begin : rsp_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && rsp_valid && rsp_ready) begin
        n_rsp++;
        check_eq("rsp_expected", VLEN'(sb_q.size() > 0), VLEN'(1));
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("rsp_vd", rsp_vd, e.vd);
          check_eq("rsp_err", VLEN'(rsp_err), VLEN'(e.err));
          if (e.lat >= 0) check_eq("rsp_lat", VLEN'(cyc - e.acc_cyc), VLEN'(e.lat));
        end
      end
    end
  end

  task automatic do_op(input logic [2:0] vsew, input logic [VLEN-1:0] vs1,
                       input logic [VLEN-1:0] vs2, input logic [VLEN-1:0] exp_vd,
                       input logic exp_err, input int exp_lat);
    bit ok;
    exp_t e;
    ok         = 1'b0;
    req_opcode = 6'h00;
    req_vsew   = vsew;
    req_optype = OpTypeVv;
    req_vs1    = vs1;
    req_vs2    = vs2;
    req_valid  = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    req_valid = 1'b0;
    check_eq("req_accepted", VLEN'(ok), VLEN'(1));
    if (ok) begin
      e.vd = exp_vd;
      e.err = exp_err;
      e.lat = exp_lat;
      e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && req_ready) done = 1'b1;
    end
    check_eq("wait_idle", VLEN'(done), VLEN'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [VLEN-1:0] a, b, exp;
    logic [VLEN-1:0] hold;
    bit              seen, stable;
    int              n0, run0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", VLEN'(req_ready), VLEN'(1));
    check_eq("rst_rsp_valid", VLEN'(rsp_valid), VLEN'(0));
    check_eq("rst_rsp_err", VLEN'(rsp_err), VLEN'(0));
    check_eq("rst_alu_run", VLEN'(alu_run), VLEN'(0));
    check_eq("rst_rsp_vd", rsp_vd, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // VV add, SEW=8: two chunk groups
    a = {16{8'h01}};
    stub_cw = 8; stub_ngroups = 2; stub_oob = 1'b0; stub_vec = vadd(a, a, 8);
    n0 = n_rsp;
    do_op(Vsew8, a, a, {16{8'h02}}, 1'b0, 2 + ALU_LAT);
    wait_idle();
    check_eq("one_rsp", VLEN'(n_rsp - n0), VLEN'(1));

    // SEW=64 split into 16-bit chunks, plus an out-of-range chunk that must be dropped
    a = {2{64'h0000_0100_0000_0000}};
    b = {2{64'h0000_0000_0000_0001}};
    stub_cw = 16; stub_ngroups = 2; stub_oob = 1'b1; stub_vec = vadd(a, b, 64);
    do_op(Vsew64, a, b, {2{64'h0000_0100_0000_0001}}, 1'b0, 2 + ALU_LAT);
    wait_idle();
    stub_oob = 1'b0;

    // Consumer stalls for 10 cycles
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    exp = vadd(a, b, 16);
    stub_cw = 16; stub_ngroups = 1; stub_vec = exp;
    rsp_ready = 1'b0;
    do_op(Vsew16, a, b, exp, 1'b0, -1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check_eq("stall_rsp_seen", VLEN'(seen), VLEN'(1));
    hold = rsp_vd;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || (rsp_vd !== hold) || req_ready) stable = 1'b0;
    end
    check_eq("stall_stable", VLEN'(stable), VLEN'(1));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle();
    check_eq("post_stall_ready", VLEN'(req_ready), VLEN'(1));
    check_eq("post_stall_valid", VLEN'(rsp_valid), VLEN'(0));

    // Wrapper never signals done: timeout abort after TIMEOUT+1 RUN cycles
    stub_hang = 1'b1;
    run0 = run_cnt;
    do_op(Vsew8, a, b, '0, 1'b1, TIMEOUT + 1);
    wait_idle();
    check_eq("timeout_run_cycles", VLEN'(run_cnt - run0), VLEN'(TIMEOUT + 1));
    check_eq("timeout_run_low", VLEN'(alu_run), VLEN'(0));

    // Reset asserted mid-RUN
    do_op(Vsew8, a, b, '0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("midrst_alu_run", VLEN'(alu_run), VLEN'(0));
    check_eq("midrst_rsp_valid", VLEN'(rsp_valid), VLEN'(0));
    check_eq("midrst_req_ready", VLEN'(req_ready), VLEN'(1));
    sb_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    stub_hang = 1'b0;
    @(posedge clk);
    #1;

    // First op after reset, SEW=32
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    exp = vadd(a, b, 32);
    stub_cw = 16; stub_ngroups = 1; stub_vec = exp;
    do_op(Vsew32, a, b, exp, 1'b0, 1 + ALU_LAT);
    wait_idle();

    // Illegal vsew immediately followed by a legal op
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    exp = vadd(a, b, 8);
    stub_cw = 8; stub_ngroups = 2; stub_vec = exp;
    run0 = run_cnt;
    do_op(3'd4, a, b, '0, 1'b1, 0);
    do_op(Vsew8, a, b, exp, 1'b0, 2 + ALU_LAT);
    wait_idle();
    check_eq("illegal_no_run", VLEN'(run_cnt - run0), VLEN'(2));

    check_eq("sb_empty", VLEN'(sb_q.size()), VLEN'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
